// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one uart_tx
// transmitter among NUM_REQ byte-stream requesters.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKT_LEN = 16,
    parameter int GAP_CYCLES  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic                 arb_idle
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [7:0]    MAX_LEN  = 8'(MAX_PKT_LEN);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]    byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;

    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic          own_valid;
    logic          own_last;
    logic [7:0]    own_data;
    logic          accept;
    logic          drop;

    function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] a, int b);
        int s;
        s = (int'(a) + b) % NUM_REQ;
        return IW'(s);
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_add(rr_ptr_q, k);
            if (!pick_vld && req_valid[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        grant     = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i]     = (state_q != IDLE) && (owner_q == IW'(i));
            req_ready[i] = (state_q == LOAD) && (owner_q == IW'(i))
                           && !uart_tx_busy;
        end
    end

    assign accept       = (state_q == LOAD) && own_valid && !uart_tx_busy;
    assign uart_tx_en   = (state_q == SEND);
    assign uart_tx_data = data_q;
    assign arb_idle     = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        last_d     = last_q;
        drop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d    = pick;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    data_d     = own_data;
                    last_d     = own_last;
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    gap_cnt_d  = '0;
                    state_d    = SEND;
                end else if (!own_valid) begin
                    // Stalled owner gives the line up after GAP_CYCLES.
                    if (gap_cnt_q == GAP_LAST) begin
                        drop = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_q || byte_cnt_q == MAX_LEN) begin
                        drop = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (drop) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_add(owner_q, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a busy model
// standing in for uart_tx, and a strobe log checked against hand values.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int BL = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   grant;
    logic            uart_tx_en;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_busy;
    logic            arb_idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .MAX_PKT_LEN(4),
        .GAP_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .uart_tx_en(uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy),
        .arb_idle(arb_idle)
    );

    logic [8:0]    mem [NR][32];
    int            head [NR] = '{default: 0};
    int            tail [NR] = '{default: 0};
    logic [NR-1:0] hs = '0;

    always @(posedge clk) hs <= req_valid & req_ready;

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            logic [8:0] nx;
            if (hs[i]) head[i] = head[i] + 1;
            nx = mem[i][5'(head[i])];
            if (req_valid[i] && !hs[i] && nx[7:0] != req_data[8*i +: 8]) begin
                errors++;
                $error("FAIL hold_req%0d: data %0h changed to %0h while stalled",
                       i, req_data[8*i +: 8], nx[7:0]);
            end
            req_valid[i]        = head[i] != tail[i];
            req_data[8*i +: 8]  = req_valid[i] ? nx[7:0] : 8'h00;
            req_last[i]         = req_valid[i] && nx[8];
        end
    end

    int   busy_left = 0;
    logic busy_force = 1'b0;
    always @(negedge clk) begin
        if (uart_tx_en) busy_left = BL;
        else if (busy_left > 0) busy_left = busy_left - 1;
    end
    assign uart_tx_busy = busy_force || (busy_left > 0);

    logic [7:0]    tx_q [$];
    logic [NR-1:0] g_q [$];
    logic          prev_en = 1'b0;
    int            dbl_en = 0;
    always @(negedge clk) begin
        if (uart_tx_en) begin
            tx_q.push_back(uart_tx_data);
            g_q.push_back(grant);
        end
        if (uart_tx_en && prev_en) dbl_en++;
        prev_en = uart_tx_en;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][5'(tail[r])] = {l, d};
        tail[r] = tail[r] + 1;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
        check(tag, 32'(tx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!arb_idle && k < 3000) begin
            tick();
            k++;
        end
        check(tag, 32'(arb_idle), 1);
    endtask

    task automatic do_reset();
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        repeat (BL + 2) tick();
        tx_q.delete();
        g_q.delete();
    endtask

    initial begin
        int k;
        int cnt;
        int rdy_seen;
        int en_seen;
        int g_cnt;
        logic [7:0] ed;
        logic [3:0] eg;

        repeat (3) tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_en", 32'(uart_tx_en), 0);
        check("rst_data", 32'(uart_tx_data), 0);
        check("rst_idle", 32'(arb_idle), 1);
        sync();
        reset = 1'b0;
        tick();

        // single requester, three-byte packet
        sync();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        wait_tx(3, "s1_count");
        wait_idle("s1_idle");
        for (int i = 0; i < 3; i++) begin
            check("s1_data", 32'(tx_q[i]), 32'h41 + i);
            check("s1_grant", 32'(g_q[i]), 4'b0001);
        end
        check("s1_grant_end", 32'(grant), 0);

        // simultaneous requests, then rotation from rr_ptr=3
        do_reset();
        sync();
        push(0, 8'h01, 1'b1);
        push(2, 8'h02, 1'b1);
        wait_tx(2, "s2a_count");
        wait_idle("s2a_idle");
        check("s2a_d0", 32'(tx_q[0]), 32'h01);
        check("s2a_g0", 32'(g_q[0]), 4'b0001);
        check("s2a_d1", 32'(tx_q[1]), 32'h02);
        check("s2a_g1", 32'(g_q[1]), 4'b0100);
        tx_q.delete();
        g_q.delete();
        sync();
        push(0, 8'h03, 1'b1);
        push(2, 8'h04, 1'b1);
        push(3, 8'h05, 1'b1);
        wait_tx(3, "s2b_count");
        wait_idle("s2b_idle");
        check("s2b_d0", 32'(tx_q[0]), 32'h05);
        check("s2b_g0", 32'(g_q[0]), 4'b1000);
        check("s2b_d1", 32'(tx_q[1]), 32'h03);
        check("s2b_g1", 32'(g_q[1]), 4'b0001);
        check("s2b_d2", 32'(tx_q[2]), 32'h04);
        check("s2b_g2", 32'(g_q[2]), 4'b0100);

        // MAX_PKT_LEN=4 forces rotation mid-packet
        do_reset();
        sync();
        for (int i = 0; i < 6; i++) push(1, 8'h10 + 8'(i), i == 5);
        k = 0;
        while (grant != 4'b0010 && k < 100) begin
            tick();
            k++;
        end
        check("s3_first_grant", 32'(grant), 4'b0010);
        sync();
        push(3, 8'hAA, 1'b1);
        wait_tx(7, "s3_count");
        wait_idle("s3_idle");
        for (int i = 0; i < 7; i++) begin
            ed = (i < 4) ? 8'h10 + 8'(i) : (i == 4) ? 8'hAA : 8'h10 + 8'(i - 1);
            eg = (i == 4) ? 4'b1000 : 4'b0010;
            check("s3_data", 32'(tx_q[i]), 32'(ed));
            check("s3_grant", 32'(g_q[i]), 32'(eg));
        end

        // GAP_CYCLES=8: stalled owner released, waiting req1 served
        do_reset();
        sync();
        push(0, 8'h55, 1'b0);
        push(1, 8'h66, 1'b1);
        wait_tx(1, "s4_first");
        k = 0;
        while (!req_ready[0] && k < 100) begin
            tick();
            k++;
        end
        check("s4_reload_ready", 32'(req_ready), 4'b0001);
        cnt = 0;
        while (grant[0] && cnt < 100) begin
            cnt++;
            tick();
        end
        check("s4_gap_len", 32'(cnt), 8);
        wait_tx(2, "s4_count");
        wait_idle("s4_idle");
        check("s4_d0", 32'(tx_q[0]), 32'h55);
        check("s4_g0", 32'(g_q[0]), 4'b0001);
        check("s4_d1", 32'(tx_q[1]), 32'h66);
        check("s4_g1", 32'(g_q[1]), 4'b0010);

        // reset during WAIT_DONE
        do_reset();
        sync();
        push(0, 8'h77, 1'b1);
        wait_tx(1, "s5_tx");
        tick();
        tick();
        check("s5_busy_phase", 32'(grant), 4'b0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s5_rst_grant", 32'(grant), 0);
        check("s5_rst_ready", 32'(req_ready), 0);
        check("s5_rst_en", 32'(uart_tx_en), 0);
        check("s5_rst_data", 32'(uart_tx_data), 0);
        check("s5_rst_idle", 32'(arb_idle), 1);
        repeat (20) tick();
        check("s5_no_reissue", 32'(tx_q.size()), 1);
        sync();
        push(0, 8'h78, 1'b1);
        push(1, 8'h79, 1'b1);
        wait_tx(3, "s5_count");
        wait_idle("s5_idle");
        check("s5_d1", 32'(tx_q[1]), 32'h78);
        check("s5_g1", 32'(g_q[1]), 4'b0001);
        check("s5_d2", 32'(tx_q[2]), 32'h79);
        check("s5_g2", 32'(g_q[2]), 4'b0010);

        // busy held high while req2 owns the line
        do_reset();
        sync();
        busy_force = 1'b1;
        push(2, 8'h9C, 1'b1);
        rdy_seen = 0;
        en_seen = 0;
        g_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_ready != '0) rdy_seen++;
            if (uart_tx_en) en_seen++;
            if (grant == 4'b0100) g_cnt++;
        end
        check("s6_ready_low", 32'(rdy_seen), 0);
        check("s6_no_strobe", 32'(en_seen), 0);
        check("s6_grant_held", 32'(g_cnt), 19);
        sync();
        busy_force = 1'b0;
        tick();
        check("s6_ready_on_fall", 32'(req_ready), 4'b0100);
        tick();
        check("s6_strobe", 32'(uart_tx_en), 1);
        check("s6_data", 32'(uart_tx_data), 32'h9C);
        wait_idle("s6_idle");
        check("s6_count", 32'(tx_q.size()), 1);

        check("single_strobe", 32'(dbl_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
